// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline sequencer: state encoding,
// memory-op type coding and drain length default.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_WAIT_STEP = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam logic       MEM_TYPE_LOAD    = 1'b0;
  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline sequencer and its surroundings
// (debug unit, ID/EX decode fields, pipeline register controls).
//
// Handshake: i_start and i_step are single-cycle pulses sampled on the rising
// clock edge; there is no back-pressure, a pulse arriving in a state that does
// not use it is dropped. All o_* controls are valid for the current cycle.
interface pipeline_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int NBITS = 32
);
  logic             i_start;
  logic             i_mode_step;
  logic             i_step;
  logic             i_id_halt;
  logic [4:0]       i_id_rs;
  logic [4:0]       i_id_rt;
  logic             i_id_uses_rt;
  logic             i_ex_flg_mem_op;
  logic             i_ex_flg_mem_type;
  logic [4:0]       i_ex_rt;
  logic             i_ex_branch_taken;
  logic             i_ex_flg_jump;

  logic             o_pc_en;
  logic             o_if_id_en;
  logic             o_if_id_flush;
  logic             o_id_ex_en;
  logic             o_id_ex_flush;
  logic             o_ex_mem_en;
  logic             o_mem_wb_en;
  logic             o_stall;
  logic             o_running;
  logic             o_halted;
  logic [NBITS-1:0] o_cycle_cnt;
  state_t           o_state;

  modport master (
    output i_start, i_mode_step, i_step, i_id_halt, i_id_rs, i_id_rt,
           i_id_uses_rt, i_ex_flg_mem_op, i_ex_flg_mem_type, i_ex_rt,
           i_ex_branch_taken, i_ex_flg_jump,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_ex_mem_en, o_mem_wb_en, o_stall, o_running, o_halted,
           o_cycle_cnt, o_state
  );

  modport slave (
    input  i_start, i_mode_step, i_step, i_id_halt, i_id_rs, i_id_rt,
           i_id_uses_rt, i_ex_flg_mem_op, i_ex_flg_mem_type, i_ex_rt,
           i_ex_branch_taken, i_ex_flg_jump,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_ex_mem_en, o_mem_wb_en, o_stall, o_running, o_halted,
           o_cycle_cnt, o_state
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard equations: load-use dependency between EX and ID,
// and control-flow redirect (taken branch or jump resolved in EX).
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       ex_flg_mem_op,
  input  logic       ex_flg_mem_type,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_branch_taken,
  input  logic       ex_flg_jump,
  output logic       ld,
  output logic       flush
);
  // $zero never carries a real dependency, so a load into it never stalls.
  assign ld = ex_flg_mem_op
            & (ex_flg_mem_type == MEM_TYPE_LOAD)
            & (ex_rt != REG_ZERO)
            & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign flush = ex_branch_taken | ex_flg_jump;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: run/step FSM, per-stage enable/flush generation,
// HALT drain and advancing-cycle counter.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int NBITS        = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
)(
  input  logic           i_clk,
  input  logic           i_rst,
  pipeline_ctrl_if.slave bus
);
  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  state_t           state, state_n;
  logic             step_mode, step_mode_n;
  logic [1:0]       drain_cnt, drain_cnt_n;
  logic [NBITS-1:0] cycle_cnt;
  logic             ld, flush, adv, halt_take;

  hazard_detect u_hazard (
    .ex_flg_mem_op   (bus.i_ex_flg_mem_op),
    .ex_flg_mem_type (bus.i_ex_flg_mem_type),
    .ex_rt           (bus.i_ex_rt),
    .id_rs           (bus.i_id_rs),
    .id_rt           (bus.i_id_rt),
    .id_uses_rt      (bus.i_id_uses_rt),
    .ex_branch_taken (bus.i_ex_branch_taken),
    .ex_flg_jump     (bus.i_ex_flg_jump),
    .ld              (ld),
    .flush           (flush)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      step_mode <= 1'b0;
      drain_cnt <= 2'd0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_n;
      step_mode <= step_mode_n;
      drain_cnt <= drain_cnt_n;
      if (adv) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  always_comb begin
    adv = 1'b0;
    case (state)
      ST_RUN, ST_STEP_EXEC: adv = 1'b1;
      ST_DRAIN:             adv = !step_mode | bus.i_step;
      default:              adv = 1'b0;
    endcase
    // A HALT behind a redirect is a wrong-path instruction; behind a stall it
    // simply waits in ID and is looked at again next cycle.
    halt_take = adv & bus.i_id_halt & !ld & !flush & (state != ST_DRAIN);

    bus.o_pc_en       = 1'b0;
    bus.o_if_id_en    = 1'b0;
    bus.o_if_id_flush = 1'b0;
    bus.o_id_ex_en    = 1'b0;
    bus.o_id_ex_flush = 1'b0;
    bus.o_ex_mem_en   = 1'b0;
    bus.o_mem_wb_en   = 1'b0;
    bus.o_stall       = 1'b0;
    if (adv) begin
      bus.o_pc_en     = 1'b1;
      bus.o_if_id_en  = 1'b1;
      bus.o_id_ex_en  = 1'b1;
      bus.o_ex_mem_en = 1'b1;
      bus.o_mem_wb_en = 1'b1;
      if (state == ST_DRAIN) begin
        bus.o_pc_en       = 1'b0;
        bus.o_if_id_flush = 1'b1;
      end else if (flush) begin
        // PC has already been redirected by EX, so fetch keeps going.
        bus.o_if_id_flush = 1'b1;
        bus.o_id_ex_flush = 1'b1;
      end else if (ld) begin
        bus.o_stall       = 1'b1;
        bus.o_pc_en       = 1'b0;
        bus.o_if_id_en    = 1'b0;
        bus.o_id_ex_flush = 1'b1;
      end else if (halt_take) begin
        bus.o_pc_en       = 1'b0;
        bus.o_if_id_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    step_mode_n = step_mode;
    drain_cnt_n = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          step_mode_n = bus.i_mode_step;
          state_n     = bus.i_mode_step ? ST_WAIT_STEP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_take) begin
          state_n     = ST_DRAIN;
          drain_cnt_n = DRAIN_LOAD;
        end
      end
      ST_WAIT_STEP: begin
        if (bus.i_step) state_n = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        if (halt_take) begin
          state_n     = ST_DRAIN;
          drain_cnt_n = DRAIN_LOAD;
        end else begin
          state_n = ST_WAIT_STEP;
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          if (drain_cnt == 2'd0) state_n = ST_HALTED;
          else                   drain_cnt_n = drain_cnt - 2'd1;
        end
      end
      ST_HALTED: state_n = ST_HALTED;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign bus.o_running   = (state == ST_RUN) | (state == ST_STEP_EXEC) |
                           (state == ST_DRAIN);
  assign bus.o_halted    = (state == ST_HALTED);
  assign bus.o_cycle_cnt = cycle_cnt;
  assign bus.o_state     = state;
endmodule
